// File: rtl/sw_debounce8_if.sv
// Signal bundle between the eight-line switch debouncer and its consumer.
// The slave modport is the debouncer side; the master modport is the driver/consumer side.
interface sw_debounce8_if;
    logic [7:0] sw_in;
    logic [7:0] clr;
    logic [7:0] x_out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] pending;
    logic       any_pending;

    modport slave (
        input  sw_in,
        input  clr,
        output x_out,
        output rise,
        output fall,
        output pending,
        output any_pending
    );

    modport master (
        output sw_in,
        output clr,
        input  x_out,
        input  rise,
        input  fall,
        input  pending,
        input  any_pending
    );
endinterface

// File: rtl/sw_debounce8.sv
// Eight independent synchronizing debouncers with edge pulses and a sticky rise record.
// Per-bit states are implied by the counter: idle (cnt=0, s2 == x_out) | counting (s2 != x_out).
module sw_debounce8 #(
    parameter int unsigned STABLE_CNT = 50000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    sw_debounce8_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [7:0]       s1_q, s1_d;
    logic [7:0]       s2_q, s2_d;
    logic [7:0]       x_q, x_d;
    logic [7:0]       rise_q, rise_d;
    logic [7:0]       fall_q, fall_d;
    logic [7:0]       pend_q, pend_d;
    logic             any_q, any_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    always_comb begin
        s1_d = bus.sw_in;
        s2_d = s1_q;
        x_d  = x_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != x_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    x_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d = x_d & ~x_q;
        fall_d = ~x_d & x_q;
        // a rise landing together with a clear keeps the bit set
        pend_d = rise_d | (pend_q & ~bus.clr);
        any_d  = |pend_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            x_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
            any_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            x_q    <= x_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
            any_q  <= any_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.x_out       = x_q;
    assign bus.rise        = rise_q;
    assign bus.fall        = fall_q;
    assign bus.pending     = pend_q;
    assign bus.any_pending = any_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Directed bench for sw_debounce8 with STABLE_CNT=4: inputs driven and outputs sampled 1ns after each rising edge.
module tb_sw_debounce8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    sw_debounce8_if bus ();

    sw_debounce8 #(.STABLE_CNT(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.sw_in = 8'h00;
        bus.clr   = 8'h00;
        rst_n     = 1'b0;
        tick(2);
        n_cmp++; if (bus.x_out !== 8'h00) begin n_err++; $display("FAIL reset_x_out: got %h expected %h", bus.x_out, 8'h00); end
        n_cmp++; if (bus.rise !== 8'h00) begin n_err++; $display("FAIL reset_rise: got %h expected %h", bus.rise, 8'h00); end
        n_cmp++; if (bus.fall !== 8'h00) begin n_err++; $display("FAIL reset_fall: got %h expected %h", bus.fall, 8'h00); end
        n_cmp++; if (bus.pending !== 8'h00) begin n_err++; $display("FAIL reset_pending: got %h expected %h", bus.pending, 8'h00); end
        n_cmp++; if (bus.any_pending !== 1'b0) begin n_err++; $display("FAIL reset_any: got %b expected 0", bus.any_pending); end
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_basic_accept();
        bus.sw_in = 8'h81;
        tick(5);
        n_cmp++; if (bus.x_out !== 8'h00) begin n_err++; $display("FAIL accept_early_x_out: got %h expected %h", bus.x_out, 8'h00); end
        tick(1);
        n_cmp++; if (bus.x_out !== 8'h81) begin n_err++; $display("FAIL accept_x_out: got %h expected %h", bus.x_out, 8'h81); end
        n_cmp++; if (bus.rise !== 8'h81) begin n_err++; $display("FAIL accept_rise: got %h expected %h", bus.rise, 8'h81); end
        n_cmp++; if (bus.pending !== 8'h81) begin n_err++; $display("FAIL accept_pending: got %h expected %h", bus.pending, 8'h81); end
        n_cmp++; if (bus.any_pending !== 1'b1) begin n_err++; $display("FAIL accept_any: got %b expected 1", bus.any_pending); end
        tick(1);
        n_cmp++; if (bus.rise !== 8'h00) begin n_err++; $display("FAIL accept_rise_width: got %h expected %h", bus.rise, 8'h00); end
    endtask

    task automatic test_glitch();
        bus.sw_in = 8'h89;
        tick(3);
        bus.sw_in = 8'h81;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            n_cmp++; if (bus.x_out !== 8'h81 || bus.rise !== 8'h00 || bus.pending !== 8'h81) begin
                n_err++; $display("FAIL glitch_reject: x_out %h rise %h pending %h expected 81 00 81", bus.x_out, bus.rise, bus.pending);
            end
        end
        // bounce 1,1,0 then constant 1
        bus.sw_in = 8'h89;
        tick(2);
        bus.sw_in = 8'h81;
        tick(1);
        bus.sw_in = 8'h89;
        tick(5);
        n_cmp++; if (bus.x_out !== 8'h81) begin n_err++; $display("FAIL bounce_early_x_out: got %h expected %h", bus.x_out, 8'h81); end
        tick(1);
        n_cmp++; if (bus.x_out !== 8'h89) begin n_err++; $display("FAIL bounce_x_out: got %h expected %h", bus.x_out, 8'h89); end
        n_cmp++; if (bus.rise !== 8'h08) begin n_err++; $display("FAIL bounce_rise: got %h expected %h", bus.rise, 8'h08); end
        n_cmp++; if (bus.pending !== 8'h89) begin n_err++; $display("FAIL bounce_pending: got %h expected %h", bus.pending, 8'h89); end
        tick(1);
    endtask

    task automatic test_fall();
        bus.sw_in = 8'h01;
        tick(5);
        n_cmp++; if (bus.fall !== 8'h00) begin n_err++; $display("FAIL fall_early: got %h expected %h", bus.fall, 8'h00); end
        tick(1);
        n_cmp++; if (bus.fall !== 8'h88) begin n_err++; $display("FAIL fall_pulse: got %h expected %h", bus.fall, 8'h88); end
        n_cmp++; if (bus.rise !== 8'h00) begin n_err++; $display("FAIL fall_no_rise: got %h expected %h", bus.rise, 8'h00); end
        n_cmp++; if (bus.x_out !== 8'h01) begin n_err++; $display("FAIL fall_x_out: got %h expected %h", bus.x_out, 8'h01); end
        n_cmp++; if (bus.pending !== 8'h89) begin n_err++; $display("FAIL fall_sticky: got %h expected %h", bus.pending, 8'h89); end
        tick(1);
        n_cmp++; if (bus.fall !== 8'h00) begin n_err++; $display("FAIL fall_width: got %h expected %h", bus.fall, 8'h00); end
    endtask

    task automatic test_clear();
        bus.clr = 8'hFF;
        tick(1);
        bus.clr = 8'h00;
        n_cmp++; if (bus.pending !== 8'h00) begin n_err++; $display("FAIL clear_all: got %h expected %h", bus.pending, 8'h00); end
        n_cmp++; if (bus.any_pending !== 1'b0) begin n_err++; $display("FAIL clear_any: got %b expected 0", bus.any_pending); end
        bus.sw_in = 8'h05;
        tick(6);
        n_cmp++; if (bus.pending !== 8'h04) begin n_err++; $display("FAIL clear_setup: got %h expected %h", bus.pending, 8'h04); end
        bus.sw_in = 8'h0D;
        tick(5);
        bus.clr = 8'h0C;
        tick(1);
        bus.clr = 8'h00;
        n_cmp++; if (bus.pending !== 8'h08) begin n_err++; $display("FAIL collide_pending: got %h expected %h", bus.pending, 8'h08); end
        n_cmp++; if (bus.rise !== 8'h08) begin n_err++; $display("FAIL collide_rise: got %h expected %h", bus.rise, 8'h08); end
        n_cmp++; if (bus.any_pending !== 1'b1) begin n_err++; $display("FAIL collide_any: got %b expected 1", bus.any_pending); end
        bus.clr = 8'h01;
        tick(1);
        bus.clr = 8'h00;
        n_cmp++; if (bus.pending !== 8'h08) begin n_err++; $display("FAIL clear_zero_bit: got %h expected %h", bus.pending, 8'h08); end
        bus.clr = 8'h08;
        tick(1);
        bus.clr = 8'h00;
        n_cmp++; if (bus.pending !== 8'h00 || bus.any_pending !== 1'b0) begin
            n_err++; $display("FAIL clear_bit3: pending %h any %b expected 00 0", bus.pending, bus.any_pending);
        end
    endtask

    task automatic test_reset_mid();
        bus.sw_in = 8'h2D;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_cmp++; if (bus.x_out !== 8'h00 || bus.rise !== 8'h00 || bus.fall !== 8'h00 || bus.pending !== 8'h00 || bus.any_pending !== 1'b0) begin
            n_err++; $display("FAIL midreset_outputs: x %h r %h f %h p %h a %b expected all zero", bus.x_out, bus.rise, bus.fall, bus.pending, bus.any_pending);
        end
        tick(5);
        n_cmp++; if (bus.x_out !== 8'h00) begin n_err++; $display("FAIL midreset_early: got %h expected %h", bus.x_out, 8'h00); end
        tick(1);
        n_cmp++; if (bus.x_out !== 8'h2D) begin n_err++; $display("FAIL midreset_x_out: got %h expected %h", bus.x_out, 8'h2D); end
        n_cmp++; if (bus.rise !== 8'h2D) begin n_err++; $display("FAIL midreset_rise: got %h expected %h", bus.rise, 8'h2D); end
        tick(1);
    endtask

    task automatic test_independent();
        logic [7:0] exp_rise;
        bus.sw_in = 8'h2C;
        tick(8);
        n_cmp++; if (bus.x_out !== 8'h2C) begin n_err++; $display("FAIL indep_setup: got %h expected %h", bus.x_out, 8'h2C); end
        bus.sw_in = 8'h2D;
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            if (c == 2) bus.sw_in = 8'h6D;
            exp_rise = (c == 6) ? 8'h01 : (c == 8) ? 8'h40 : 8'h00;
            n_cmp++; if (bus.rise !== exp_rise) begin
                n_err++; $display("FAIL indep_rise_c%0d: got %h expected %h", c, bus.rise, exp_rise);
            end
        end
        n_cmp++; if (bus.x_out !== 8'h6D) begin n_err++; $display("FAIL indep_x_out: got %h expected %h", bus.x_out, 8'h6D); end
    endtask

    initial begin
        test_reset();
        test_basic_accept();
        test_glitch();
        test_fall();
        test_clear();
        test_reset_mid();
        test_independent();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
